// File: rtl/synth_pkg.sv
// Shared constants and waveform shaping for the note oscillator.
package synth_pkg;

    localparam int unsigned PHASE_WIDTH  = 22;
    localparam int unsigned SAMPLE_WIDTH = 16;
    localparam int unsigned NOTE_WIDTH   = 6;
    localparam int unsigned SAMPLE_RATE  = 48000;

    localparam logic [1:0] WAVE_SAW    = 2'd0;
    localparam logic [1:0] WAVE_SQUARE = 2'd1;
    localparam logic [1:0] WAVE_TRI    = 2'd2;
    localparam logic [1:0] WAVE_SILENT = 2'd3;

    localparam logic [NOTE_WIDTH-1:0] NOTE_REST = 6'd0;
    localparam logic [NOTE_WIDTH-1:0] NOTE_A4   = 6'd49;

    localparam logic [SAMPLE_WIDTH-1:0] SQUARE_POS = 16'h3FFF;
    localparam logic [SAMPLE_WIDTH-1:0] SQUARE_NEG = 16'hC001;

    // Map the top 16 phase bits onto a signed sample; offset-binary flips the MSB.
    function automatic logic [SAMPLE_WIDTH-1:0] wave_sample(
        input logic [1:0]             sel,
        input logic [PHASE_WIDTH-1:0] phase
    );
        logic [SAMPLE_WIDTH-1:0] u;
        logic [SAMPLE_WIDTH-2:0] t;
        logic [SAMPLE_WIDTH-1:0] res;
        u   = phase[PHASE_WIDTH-1 -: SAMPLE_WIDTH];
        t   = u[SAMPLE_WIDTH-1] ? ~u[SAMPLE_WIDTH-2:0] : u[SAMPLE_WIDTH-2:0];
        res = '0;
        case (sel)
            WAVE_SAW:    res = {~u[SAMPLE_WIDTH-1], u[SAMPLE_WIDTH-2:0]};
            WAVE_SQUARE: res = u[SAMPLE_WIDTH-1] ? SQUARE_NEG : SQUARE_POS;
            WAVE_TRI:    res = {~t[SAMPLE_WIDTH-2], t[SAMPLE_WIDTH-3:0], 1'b0};
            default:     res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/note_step_rom.sv
// Equal-tempered phase increment per note: round(440*2^((n-49)/12)*2^22/48000).
module note_step_rom
    import synth_pkg::*;
(
    input  logic [NOTE_WIDTH-1:0]  note,
    output logic [PHASE_WIDTH-1:0] step
);

    always_comb begin
        step = '0;
        case (note)
            6'd1:  step = 22'd2403;   6'd2:  step = 22'd2546;   6'd3:  step = 22'd2697;
            6'd4:  step = 22'd2858;   6'd5:  step = 22'd3028;   6'd6:  step = 22'd3208;
            6'd7:  step = 22'd3398;   6'd8:  step = 22'd3600;   6'd9:  step = 22'd3815;
            6'd10: step = 22'd4041;   6'd11: step = 22'd4282;   6'd12: step = 22'd4536;
            6'd13: step = 22'd4806;   6'd14: step = 22'd5092;   6'd15: step = 22'd5395;
            6'd16: step = 22'd5715;   6'd17: step = 22'd6055;   6'd18: step = 22'd6415;
            6'd19: step = 22'd6797;   6'd20: step = 22'd7201;   6'd21: step = 22'd7629;
            6'd22: step = 22'd8083;   6'd23: step = 22'd8563;   6'd24: step = 22'd9072;
            6'd25: step = 22'd9612;   6'd26: step = 22'd10184;  6'd27: step = 22'd10789;
            6'd28: step = 22'd11431;  6'd29: step = 22'd12110;  6'd30: step = 22'd12830;
            6'd31: step = 22'd13593;  6'd32: step = 22'd14402;  6'd33: step = 22'd15258;
            6'd34: step = 22'd16165;  6'd35: step = 22'd17127;  6'd36: step = 22'd18145;
            6'd37: step = 22'd19224;  6'd38: step = 22'd20367;  6'd39: step = 22'd21578;
            6'd40: step = 22'd22861;  6'd41: step = 22'd24221;  6'd42: step = 22'd25661;
            6'd43: step = 22'd27187;  6'd44: step = 22'd28803;  6'd45: step = 22'd30516;
            6'd46: step = 22'd32331;  6'd47: step = 22'd34253;  6'd48: step = 22'd36290;
            6'd49: step = 22'd38448;  6'd50: step = 22'd40734;  6'd51: step = 22'd43156;
            6'd52: step = 22'd45722;  6'd53: step = 22'd48441;  6'd54: step = 22'd51322;
            6'd55: step = 22'd54373;  6'd56: step = 22'd57607;  6'd57: step = 22'd61032;
            6'd58: step = 22'd64661;  6'd59: step = 22'd68506;  6'd60: step = 22'd72580;
            6'd61: step = 22'd76896;  6'd62: step = 22'd81468;  6'd63: step = 22'd86312;
            default: step = '0;
        endcase
    end

endmodule

// File: rtl/note_osc.sv
// Phase-accumulator note oscillator; note changes land on the next phase wrap.
module note_osc
    import synth_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    generate_next,
    input  logic                    note_load,
    input  logic [NOTE_WIDTH-1:0]   note,
    input  logic [1:0]              wave_sel,
    output logic [SAMPLE_WIDTH-1:0] sample_out,
    output logic                    sample_ready,
    output logic                    wrapped,
    output logic [NOTE_WIDTH-1:0]   active_note
);

    logic [PHASE_WIDTH-1:0] phase;
    logic [PHASE_WIDTH-1:0] step;
    logic [PHASE_WIDTH-1:0] rom_step_c;
    logic [NOTE_WIDTH-1:0]  pending_note;
    logic                   pending_valid;
    logic                   s1_valid;
    logic                   wrap_q;

    logic [NOTE_WIDTH-1:0]  apply_note_c;
    logic                   apply_valid_c;
    logic [PHASE_WIDTH:0]   sum_c;
    logic                   restart_c;
    logic                   apply_c;

    // A note_load arriving with the apply wins over the older pending value.
    always_comb begin
        apply_note_c  = note_load ? note : pending_note;
        apply_valid_c = note_load | pending_valid;
        sum_c         = {1'b0, phase} + {1'b0, step};
        restart_c     = generate_next && apply_valid_c && (step == '0);
        apply_c       = restart_c || (generate_next && apply_valid_c && sum_c[PHASE_WIDTH]);
    end

    note_step_rom u_step_rom (
        .note (apply_note_c),
        .step (rom_step_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase         <= '0;
            step          <= '0;
            active_note   <= '0;
            pending_note  <= '0;
            pending_valid <= 1'b0;
            s1_valid      <= 1'b0;
            wrap_q        <= 1'b0;
            sample_out    <= '0;
            sample_ready  <= 1'b0;
            wrapped       <= 1'b0;
        end else begin
            s1_valid <= generate_next;

            // Stage 1: advance phase; an idle oscillator restarts from zero on a new note.
            if (restart_c) begin
                phase  <= rom_step_c;
                wrap_q <= 1'b0;
            end else if (generate_next) begin
                phase  <= sum_c[PHASE_WIDTH-1:0];
                wrap_q <= sum_c[PHASE_WIDTH];
            end

            if (apply_c) begin
                step          <= rom_step_c;
                active_note   <= apply_note_c;
                pending_note  <= apply_note_c;
                pending_valid <= 1'b0;
            end else if (note_load) begin
                pending_note  <= note;
                pending_valid <= 1'b1;
            end

            // Stage 2: shape the updated phase.
            sample_ready <= s1_valid;
            wrapped      <= s1_valid & wrap_q;
            if (s1_valid) begin
                sample_out <= (step == '0) ? '0 : wave_sample(wave_sel, phase);
            end
        end
    end

endmodule
